// File: rtl/atm_account_arbiter.sv
// rtl/atm_account_arbiter.sv - round-robin shared-balance arbiter for ATM terminals
// Optional per-withdraw cap enabled by defining ATM_WD_LIMIT_EN.
module atm_account_arbiter #(
    parameter int                 NUM_TERM = 2,
    parameter int                 BAL_W    = 32,
    parameter logic [BAL_W-1:0]   INIT_BAL = 32'h000F4240,
    parameter int                 WD_LIMIT = 20000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_TERM-1:0]       req,
    input  logic [2*NUM_TERM-1:0]     op,
    input  logic [BAL_W*NUM_TERM-1:0] amount,
    output logic [NUM_TERM-1:0]       gnt,
    output logic [NUM_TERM-1:0]       done,
    output logic [1:0]                status,
    output logic [BAL_W-1:0]          balance,
    output logic                      busy
);

`ifdef ATM_WD_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    localparam logic [BAL_W-1:0] WD_LIMIT_V = BAL_W'(WD_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_EXEC, S_RESP} state_t;

    state_t                state_q;
    logic [1:0]            win_q;
    logic [1:0]            ptr_q;
    logic [1:0]            op_q;
    logic [BAL_W-1:0]      amt_q;
    logic [NUM_TERM-1:0]   gnt_q;
    logic [NUM_TERM-1:0]   done_q;
    logic [1:0]            status_q;
    logic [BAL_W-1:0]      bal_q;
    logic                  busy_q;

    logic                  pick_found;
    logic [1:0]            pick_idx;
    logic [NUM_TERM-1:0]   pick_oh;
    logic [1:0]            ptr_d;
    int                    cand;
    logic [1:0]            sel_op;
    logic [BAL_W-1:0]      sel_amt;
    logic [BAL_W:0]        sum_w;
    logic [1:0]            exec_status;
    logic [BAL_W-1:0]      bal_d;

    // Scan from the lowest priority upward so the highest-priority requester is written last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 0;
        for (int k = NUM_TERM - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_TERM) cand = cand - NUM_TERM;
            if (req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = 2'(cand);
            end
        end
        for (int i = 0; i < NUM_TERM; i++) begin
            pick_oh[i] = (pick_idx == 2'(i));
        end
        ptr_d = (pick_idx == 2'(NUM_TERM - 1)) ? 2'd0 : pick_idx + 2'd1;
    end

    always_comb begin
        sel_op  = 2'd0;
        sel_amt = '0;
        for (int i = 0; i < NUM_TERM; i++) begin
            if (win_q == 2'(i)) begin
                sel_op  = op[2*i +: 2];
                sel_amt = amount[BAL_W*i +: BAL_W];
            end
        end
    end

    assign sum_w = {1'b0, bal_q} + {1'b0, amt_q};

    always_comb begin
        exec_status = 2'b00;
        bal_d       = bal_q;
        case (op_q)
            2'b01: begin
                if (sum_w[BAL_W]) exec_status = 2'b10;
                else              bal_d       = sum_w[BAL_W-1:0];
            end
            2'b10: begin
                if (LIMIT_EN && (amt_q > WD_LIMIT_V)) exec_status = 2'b11;
                else if (amt_q > bal_q)               exec_status = 2'b01;
                else                                  bal_d       = bal_q - amt_q;
            end
            2'b11:   exec_status = 2'b11;
            default: exec_status = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            win_q    <= 2'd0;
            ptr_q    <= 2'd0;
            op_q     <= 2'd0;
            amt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            status_q <= 2'b00;
            bal_q    <= INIT_BAL;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        gnt_q   <= pick_oh;
                        win_q   <= pick_idx;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    op_q    <= sel_op;
                    amt_q   <= sel_amt;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    bal_q    <= bal_d;
                    status_q <= exec_status;
                    done_q   <= gnt_q;
                    state_q  <= S_RESP;
                end
                S_RESP: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign status  = status_q;
    assign balance = bal_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// tb/tb_atm_account_arbiter.sv - self-checking bench for atm_account_arbiter
module tb_atm_account_arbiter;

    localparam int NT = 3;
    localparam int BW = 32;
    localparam logic [31:0] INIT_A = 32'h000F4240;
    localparam logic [31:0] INIT_B = 32'hFFFFFFF0;
`ifdef ATM_WD_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NT-1:0]     req;
    logic [2*NT-1:0]   op;
    logic [BW*NT-1:0]  amount;
    logic [NT-1:0]     gnt_a, done_a, gnt_b, done_b;
    logic [1:0]        status_a, status_b;
    logic [BW-1:0]     bal_a, bal_b;
    logic              busy_a, busy_b;

    atm_account_arbiter #(.NUM_TERM(NT), .BAL_W(BW), .INIT_BAL(INIT_A), .WD_LIMIT(20000)) dut_a (
        .clk(clk), .reset(reset), .req(req), .op(op), .amount(amount),
        .gnt(gnt_a), .done(done_a), .status(status_a), .balance(bal_a), .busy(busy_a));

    atm_account_arbiter #(.NUM_TERM(NT), .BAL_W(BW), .INIT_BAL(INIT_B), .WD_LIMIT(20000)) dut_b (
        .clk(clk), .reset(reset), .req(req), .op(op), .amount(amount),
        .gnt(gnt_b), .done(done_b), .status(status_b), .balance(bal_b), .busy(busy_b));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] mbal_a, mbal_b;
    int mptr;

    typedef struct {
        int          term;
        logic [1:0]  op;
        logic [31:0] amt;
        logic [1:0]  st;
        logic [31:0] bal;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NT-1:0] onehot(input int t);
        logic [NT-1:0] v;
        v = '0;
        v[t] = 1'b1;
        return v;
    endfunction

    // Reference arithmetic written directly from the account rules.
    function automatic void model_apply(input logic [31:0] b, input logic [1:0] o, input logic [31:0] a,
                                        output logic [1:0] st, output logic [31:0] nb);
        logic [63:0] s;
        st = 2'b00;
        nb = b;
        s  = {32'b0, b} + {32'b0, a};
        case (o)
            2'b01: if (s > 64'hFFFF_FFFF) st = 2'b10; else nb = s[31:0];
            2'b10: if (LIM && a > 32'd20000) st = 2'b11;
                   else if (a > b) st = 2'b01;
                   else nb = b - a;
            2'b11: st = 2'b11;
            default: st = 2'b00;
        endcase
    endfunction

    task automatic model_check(input int term, input logic [1:0] o, input logic [31:0] a, input string tag);
        logic [1:0]  sa, sb;
        logic [31:0] na, nb;
        model_apply(mbal_a, o, a, sa, na);
        model_apply(mbal_b, o, a, sb, nb);
        chk({tag, "_done_a"}, done_a, onehot(term));
        chk({tag, "_done_b"}, done_b, onehot(term));
        chk({tag, "_status_a"}, status_a, sa);
        chk({tag, "_bal_a"}, bal_a, na);
        chk({tag, "_status_b"}, status_b, sb);
        chk({tag, "_bal_b"}, bal_b, nb);
        mbal_a = na;
        mbal_b = nb;
        mptr   = (term + 1) % NT;
    endtask

    task automatic set_term(input int t, input logic [1:0] o, input logic [31:0] a);
        op[2*t +: 2]     = o;
        amount[BW*t +: BW] = a;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_a == '0 && n < 12);
        if (done_a == '0) chk("done_timeout", 64'(n), 64'd0);
    endtask

    task automatic do_single(input int t, input logic [1:0] o, input logic [31:0] a,
                             input logic [1:0] est, input logic [31:0] ebal, input string tag);
        int n;
        @(negedge clk);
        set_term(t, o, a);
        req[t] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_gnt"}, gnt_a, onehot(t));
                chk({tag, "_busy"}, busy_a, 1'b1);
            end
        end while (done_a == '0 && n < 12);
        chk({tag, "_latency"}, 64'(n), 64'd3);
        chk({tag, "_tbl_status"}, status_a, est);
        chk({tag, "_tbl_bal"}, bal_a, ebal);
        model_check(t, o, a, tag);
        req[t] = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_busy"}, busy_a, 1'b0);
        chk({tag, "_idle_gnt"}, gnt_a, '0);
        chk({tag, "_idle_done"}, done_a, '0);
    endtask

    initial begin
        logic [31:0] lb;
        int n, w, dcount;
        bit pend[NT];
        logic [1:0]  pop[NT];
        logic [31:0] pamt[NT];

        lb = LIM ? 32'd980000 : 32'd959999;
        tbl[0] = '{0, 2'b00, 32'd0,       2'b00, 32'd1000000};
        tbl[1] = '{1, 2'b10, 32'd1000001, 2'b01, 32'd1000000};
        tbl[2] = '{0, 2'b10, 32'd1000000, 2'b00, 32'd0};
        tbl[3] = '{1, 2'b01, 32'd1000000, 2'b00, 32'd1000000};
        tbl[4] = '{0, 2'b10, 32'd20000,   2'b00, 32'd980000};
        tbl[5] = '{1, 2'b10, 32'd20001,   LIM ? 2'b11 : 2'b00, lb};
        tbl[6] = '{2, 2'b11, 32'd5,       2'b11, lb};
        tbl[7] = '{0, 2'b01, 32'd0,       2'b00, lb};
        tbl[8] = '{2, 2'b10, 32'd0,       2'b00, lb};
        tbl[9] = '{1, 2'b00, 32'd7,       2'b00, lb};

        reset = 1'b0; req = '0; op = '0; amount = '0;
        mbal_a = INIT_A; mbal_b = INIT_B; mptr = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_gnt", gnt_a, '0);
        chk("rst_done", done_a, '0);
        chk("rst_status", status_a, 2'b00);
        chk("rst_bal_a", bal_a, INIT_A);
        chk("rst_bal_b", bal_b, INIT_B);
        chk("rst_busy", busy_a, 1'b0);

        for (int i = 0; i < 10; i++)
            do_single(tbl[i].term, tbl[i].op, tbl[i].amt, tbl[i].st, tbl[i].bal, $sformatf("tbl%0d", i));

        // Two terminals held high continuously: service must alternate.
        @(negedge clk);
        set_term(0, 2'b01, 32'd100);
        set_term(1, 2'b01, 32'd100);
        req = 3'b011;
        for (int k = 0; k < 4; k++) begin
            wait_done(n);
            chk($sformatf("rr%0d_spacing", k), 64'(n), (k == 0) ? 64'd3 : 64'd4);
            model_check(k % 2, 2'b01, 32'd100, $sformatf("rr%0d", k));
        end
        req = '0;
        @(negedge clk);
        chk("rr_idle_busy", busy_a, 1'b0);

        for (int t = 0; t < NT; t++) pend[t] = 1'b0;
        for (int it = 0; it < 40; it++) begin
            for (int t = 0; t < NT; t++) begin
                if (!pend[t] && ($urandom_range(0, 1) == 1 || (it % NT == t))) begin
                    pend[t] = 1'b1;
                    pop[t]  = 2'($urandom_range(0, 3));
                    case ($urandom_range(0, 3))
                        0: pamt[t] = 32'd0;
                        1: pamt[t] = $urandom_range(0, 40000);
                        2: pamt[t] = $urandom;
                        default: pamt[t] = mbal_a + $urandom_range(0, 2) - 32'd1;
                    endcase
                    set_term(t, pop[t], pamt[t]);
                    req[t] = 1'b1;
                end
            end
            wait_done(n);
            w = -1;
            for (int k = NT - 1; k >= 0; k--)
                if (pend[(mptr + k) % NT]) w = (mptr + k) % NT;
            if (w < 0) w = 0;
            model_check(w, pop[w], pamt[w], $sformatf("rnd%0d", it));
            pend[w] = 1'b0;
            req[w]  = 1'b0;
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Reset asserted while the deposit is in EXEC.
        @(negedge clk);
        set_term(0, 2'b01, 32'd500);
        req[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt_a, '0);
        chk("mid_rst_done", done_a, '0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_bal", bal_a, INIT_A);
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_a != '0) dcount++;
            if (k == 1) req = '0;
            if (k == 2) reset = 1'b1;
        end
        chk("mid_rst_no_done", 64'(dcount), 64'd0);
        chk("mid_rst_bal_after", bal_a, 32'd1000000);
        mbal_a = INIT_A; mbal_b = INIT_B; mptr = 0;

        do_single(1, 2'b01, 32'h20, 2'b00, 32'd1000032, "ovf");
        chk("ovf_status_b", status_b, 2'b10);
        chk("ovf_bal_b", bal_b, 32'hFFFFFFF0);
        do_single(1, 2'b11, 32'd0, 2'b11, 32'd1000032, "ill");
        chk("ill_status_b", status_b, 2'b11);
        chk("ill_bal_b", bal_b, 32'hFFFFFFF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
